// File: rtl/multiexp_axi_mem_pkg.sv
// Shared types and constants for the multiexp AXI memory responder.
// Holds the write/read FSM state encodings and the LFSR used by the optional
// backpressure build (MULTIEXP_AXI_MEM_BACKPRESSURE_EN).
package multiexp_axi_mem_pkg;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_DATA,
        WR_RESP
    } wr_state_t;

    typedef enum logic {
        RD_IDLE,
        RD_BURST
    } rd_state_t;

    // Maximal-length 16-bit Galois LFSR (x^16 + x^14 + x^13 + x^11 + 1)
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

endpackage

// File: rtl/multiexp_axi_mem_bram.sv
// Simple dual-port RAM: one byte-enabled write port, one registered read port.
// A read and write to the same word in the same cycle returns the old data.
module multiexp_axi_mem_bram #(
    parameter int C_DATA_WIDTH = 512,
    parameter int C_MEM_DEPTH  = 1024
) (
    input  logic                            ap_clk,
    input  logic                            i_we,
    input  logic [$clog2(C_MEM_DEPTH)-1:0]  i_waddr,
    input  logic [C_DATA_WIDTH-1:0]         i_wdata,
    input  logic [C_DATA_WIDTH/8-1:0]       i_wstrb,
    input  logic                            i_re,
    input  logic [$clog2(C_MEM_DEPTH)-1:0]  i_raddr,
    output logic [C_DATA_WIDTH-1:0]         o_rdata
);
    localparam int BYTES = C_DATA_WIDTH / 8;

    logic [C_DATA_WIDTH-1:0] r_mem [C_MEM_DEPTH];
    logic [C_DATA_WIDTH-1:0] r_rdata;

    // Read-first port pair: the read samples the array before this edge's write lands
    always_ff @(posedge ap_clk) begin
        if (i_re)
            r_rdata <= r_mem[i_raddr];
        if (i_we) begin
            for (int b = 0; b < BYTES; b++) begin
                if (i_wstrb[b])
                    r_mem[i_waddr][b*8 +: 8] <= i_wdata[b*8 +: 8];
            end
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/multiexp_axi_mem_responder.sv
// AXI4 responder backed by an on-chip memory image (INCR bursts, full-width beats).
// Independent write (AW/W/B) and read (AR/R) FSMs; reads run through a 2-entry
// skid buffer so 1 beat/cycle is sustained across the 1-cycle RAM latency.
// Optional build macro MULTIEXP_AXI_MEM_BACKPRESSURE_EN inserts LFSR-driven stalls
// on awready/wready/arready and withholds rvalid on some cycles.
module multiexp_axi_mem_responder
    import multiexp_axi_mem_pkg::*;
#(
    parameter int          C_ADDR_WIDTH = 64,
    parameter int          C_DATA_WIDTH = 512,
    parameter int          C_MEM_DEPTH  = 1024,
    parameter logic [63:0] C_BASE_ADDR  = 64'h0
) (
    input  logic                        ap_clk,
    input  logic                        areset,
    input  logic                        s_axi_awvalid,
    output logic                        s_axi_awready,
    input  logic [C_ADDR_WIDTH-1:0]     s_axi_awaddr,
    input  logic [7:0]                  s_axi_awlen,
    input  logic                        s_axi_wvalid,
    output logic                        s_axi_wready,
    input  logic [C_DATA_WIDTH-1:0]     s_axi_wdata,
    input  logic [C_DATA_WIDTH/8-1:0]   s_axi_wstrb,
    input  logic                        s_axi_wlast,
    output logic                        s_axi_bvalid,
    input  logic                        s_axi_bready,
    input  logic                        s_axi_arvalid,
    output logic                        s_axi_arready,
    input  logic [C_ADDR_WIDTH-1:0]     s_axi_araddr,
    input  logic [7:0]                  s_axi_arlen,
    output logic                        s_axi_rvalid,
    input  logic                        s_axi_rready,
    output logic [C_DATA_WIDTH-1:0]     s_axi_rdata,
    output logic                        s_axi_rlast,
    output logic                        o_wlast_err
);
    localparam int BYTES = C_DATA_WIDTH / 8;
    localparam int OFFS  = $clog2(BYTES);
    localparam int IDXW  = $clog2(C_MEM_DEPTH);

    // ---------------- address to word index ----------------
    logic [C_ADDR_WIDTH-1:0] w_aw_off;
    logic [C_ADDR_WIDTH-1:0] w_ar_off;
    logic [IDXW-1:0]         w_aw_idx;
    logic [IDXW-1:0]         w_ar_idx;

    // Low (sub-word) bits are dropped and high bits fold modulo the depth
    assign w_aw_off = s_axi_awaddr - C_ADDR_WIDTH'(C_BASE_ADDR);
    assign w_ar_off = s_axi_araddr - C_ADDR_WIDTH'(C_BASE_ADDR);
    assign w_aw_idx = w_aw_off[OFFS +: IDXW];
    assign w_ar_idx = w_ar_off[OFFS +: IDXW];

    // ---------------- stall gating ----------------
    logic w_aw_ok;
    logic w_w_ok;
    logic w_ar_ok;
    logic w_r_hold;
    logic w_rvalid;
    logic w_unused;

`ifdef MULTIEXP_AXI_MEM_BACKPRESSURE_EN
    logic [15:0] r_lfsr;
    logic        r_rv_shown;

    // Free-running LFSR; each ready uses its own bit pair so stalls are uncorrelated
    always_ff @(posedge ap_clk) begin
        if (areset)
            r_lfsr <= LFSR_SEED;
        else
            r_lfsr <= lfsr_next(r_lfsr);
    end

    // Remember an offered-but-unaccepted beat so rvalid is never withdrawn once shown
    always_ff @(posedge ap_clk) begin
        if (areset)
            r_rv_shown <= 1'b0;
        else
            r_rv_shown <= w_rvalid & ~s_axi_rready;
    end

    assign w_aw_ok  = ~(r_lfsr[0] & r_lfsr[1]);
    assign w_w_ok   = ~(r_lfsr[4] & r_lfsr[5]);
    assign w_ar_ok  = ~(r_lfsr[8] & r_lfsr[9]);
    assign w_r_hold = r_lfsr[12] & r_lfsr[13] & ~r_rv_shown;
    assign w_unused = ^{w_aw_off, w_ar_off, r_lfsr};
`else
    assign w_aw_ok  = 1'b1;
    assign w_w_ok   = 1'b1;
    assign w_ar_ok  = 1'b1;
    assign w_r_hold = 1'b0;
    assign w_unused = ^{w_aw_off, w_ar_off};
`endif

    // ---------------- write channel ----------------
    wr_state_t       r_wr_state;
    logic            r_awready;
    logic            r_wready;
    logic            r_bvalid;
    logic            r_wlast_err;
    logic [IDXW-1:0] r_wr_idx;
    logic [7:0]      r_wr_cnt;
    logic            w_wr_hs;

    assign w_wr_hs = s_axi_wvalid & r_wready;

    // Write FSM: AW latch, W beats counted down from awlen, then a single B response
    always_ff @(posedge ap_clk) begin
        if (areset) begin
            r_wr_state  <= WR_IDLE;
            r_awready   <= 1'b0;
            r_wready    <= 1'b0;
            r_bvalid    <= 1'b0;
            r_wlast_err <= 1'b0;
            r_wr_idx    <= '0;
            r_wr_cnt    <= '0;
        end else begin
            case (r_wr_state)
                WR_IDLE: begin
                    if (s_axi_awvalid && r_awready) begin
                        r_wr_state <= WR_DATA;
                        r_awready  <= 1'b0;
                        r_wr_idx   <= w_aw_idx;
                        r_wr_cnt   <= s_axi_awlen;
                        r_wready   <= w_w_ok;
                    end else begin
                        r_awready  <= w_aw_ok;
                    end
                end
                WR_DATA: begin
                    if (w_wr_hs) begin
                        // The beat count decides the end of burst; wlast is only audited
                        if (s_axi_wlast != (r_wr_cnt == 8'd0))
                            r_wlast_err <= 1'b1;
                        if (r_wr_cnt == 8'd0) begin
                            r_wr_state <= WR_RESP;
                            r_wready   <= 1'b0;
                            r_bvalid   <= 1'b1;
                        end else begin
                            r_wr_cnt   <= r_wr_cnt - 8'd1;
                            r_wr_idx   <= r_wr_idx + IDXW'(1);
                            r_wready   <= w_w_ok;
                        end
                    end else begin
                        r_wready <= w_w_ok;
                    end
                end
                WR_RESP: begin
                    // awready stays low here, so the next AW waits at least one idle cycle
                    if (s_axi_bready) begin
                        r_bvalid   <= 1'b0;
                        r_wr_state <= WR_IDLE;
                    end
                end
                default: begin
                    r_wr_state <= WR_IDLE;
                    r_awready  <= 1'b0;
                    r_wready   <= 1'b0;
                    r_bvalid   <= 1'b0;
                end
            endcase
        end
    end

    // ---------------- read channel ----------------
    rd_state_t               r_rd_state;
    logic                    r_arready;
    logic [IDXW-1:0]         r_iss_idx;
    logic [8:0]              r_iss_left;
    logic                    r_infl;
    logic                    r_infl_last;
    logic [C_DATA_WIDTH-1:0] r_q_data [2];
    logic                    r_q_last [2];
    logic                    r_q_wp;
    logic                    r_q_rp;
    logic [1:0]              r_q_cnt;
    logic                    w_pop;
    logic                    w_issue;
    logic [2:0]              w_occ;
    logic [C_DATA_WIDTH-1:0] w_bram_rdata;

    assign w_rvalid = (r_q_cnt != 2'd0) & ~w_r_hold;
    assign w_pop    = w_rvalid & s_axi_rready;

    // Skid entries held after this cycle, counting the beat already in the RAM pipe
    assign w_occ   = {1'b0, r_q_cnt} + {2'b0, r_infl} - {2'b0, w_pop};
    assign w_issue = (r_rd_state == RD_BURST) && (r_iss_left != 9'd0) && (w_occ < 3'd2);

    // Read FSM plus RAM issue pipeline and 2-entry skid buffer
    always_ff @(posedge ap_clk) begin
        if (areset) begin
            r_rd_state  <= RD_IDLE;
            r_arready   <= 1'b0;
            r_iss_idx   <= '0;
            r_iss_left  <= '0;
            r_infl      <= 1'b0;
            r_infl_last <= 1'b0;
            r_q_wp      <= 1'b0;
            r_q_rp      <= 1'b0;
            r_q_cnt     <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                r_q_data[i] <= '0;
                r_q_last[i] <= 1'b0;
            end
        end else begin
            if (r_infl) begin
                r_q_data[r_q_wp] <= w_bram_rdata;
                r_q_last[r_q_wp] <= r_infl_last;
                r_q_wp           <= ~r_q_wp;
            end
            if (w_pop)
                r_q_rp <= ~r_q_rp;
            r_q_cnt     <= r_q_cnt + 2'(r_infl) - 2'(w_pop);
            r_infl      <= w_issue;
            r_infl_last <= w_issue && (r_iss_left == 9'd1);
            if (w_issue) begin
                r_iss_idx  <= r_iss_idx + IDXW'(1);
                r_iss_left <= r_iss_left - 9'd1;
            end

            case (r_rd_state)
                RD_IDLE: begin
                    if (s_axi_arvalid && r_arready) begin
                        r_rd_state <= RD_BURST;
                        r_arready  <= 1'b0;
                        r_iss_idx  <= w_ar_idx;
                        r_iss_left <= {1'b0, s_axi_arlen} + 9'd1;
                    end else begin
                        r_arready  <= w_ar_ok;
                    end
                end
                RD_BURST: begin
                    if (w_pop && r_q_last[r_q_rp])
                        r_rd_state <= RD_IDLE;
                end
                default: begin
                    r_rd_state <= RD_IDLE;
                    r_arready  <= 1'b0;
                end
            endcase
        end
    end

    multiexp_axi_mem_bram #(
        .C_DATA_WIDTH (C_DATA_WIDTH),
        .C_MEM_DEPTH  (C_MEM_DEPTH)
    ) u_bram (
        .ap_clk  (ap_clk),
        .i_we    (w_wr_hs),
        .i_waddr (r_wr_idx),
        .i_wdata (s_axi_wdata),
        .i_wstrb (s_axi_wstrb),
        .i_re    (w_issue),
        .i_raddr (r_iss_idx),
        .o_rdata (w_bram_rdata)
    );

    assign s_axi_awready = r_awready;
    assign s_axi_wready  = r_wready;
    assign s_axi_bvalid  = r_bvalid;
    assign s_axi_arready = r_arready;
    assign s_axi_rvalid  = w_rvalid;
    assign s_axi_rdata   = r_q_data[r_q_rp];
    assign s_axi_rlast   = w_rvalid & r_q_last[r_q_rp];
    assign o_wlast_err   = r_wlast_err;

endmodule

// File: tb/tb_multiexp_axi_mem_responder.sv
// Self-checking bench for multiexp_axi_mem_responder (default build).
// A flat word-array model of the memory supplies every expected read beat.
module tb_multiexp_axi_mem_responder;
    localparam int AW    = 64;
    localparam int DW    = 512;
    localparam int SW    = DW / 8;
    localparam int DEPTH = 1024;
    localparam int LIM   = 1000;

    logic          ap_clk = 1'b0;
    logic          areset = 1'b1;
    logic          s_axi_awvalid = 1'b0, s_axi_awready;
    logic [AW-1:0] s_axi_awaddr = '0;
    logic [7:0]    s_axi_awlen = '0;
    logic          s_axi_wvalid = 1'b0, s_axi_wready;
    logic [DW-1:0] s_axi_wdata = '0;
    logic [SW-1:0] s_axi_wstrb = '0;
    logic          s_axi_wlast = 1'b0;
    logic          s_axi_bvalid, s_axi_bready = 1'b0;
    logic          s_axi_arvalid = 1'b0, s_axi_arready;
    logic [AW-1:0] s_axi_araddr = '0;
    logic [7:0]    s_axi_arlen = '0;
    logic          s_axi_rvalid, s_axi_rready = 1'b0;
    logic [DW-1:0] s_axi_rdata;
    logic          s_axi_rlast;
    logic          o_wlast_err;

    always #5 ap_clk = ~ap_clk;

    multiexp_axi_mem_responder dut (
        .ap_clk(ap_clk), .areset(areset),
        .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
        .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .s_axi_rdata(s_axi_rdata), .s_axi_rlast(s_axi_rlast),
        .o_wlast_err(o_wlast_err)
    );

    logic [DW-1:0] mem_m [DEPTH];
    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] rnd512();
        logic [DW-1:0] r;
        for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic int widx(input logic [AW-1:0] a);
        return int'((a / SW) % DEPTH);
    endfunction

    // all tasks are entered at a negedge and return at a negedge
    task automatic aw_send(input logic [AW-1:0] a, input logic [7:0] l);
        int t = 0;
        s_axi_awaddr = a; s_axi_awlen = l; s_axi_awvalid = 1'b1;
        while (!s_axi_awready && t < LIM) begin @(negedge ap_clk); t++; end
        chk("aw_handshake", s_axi_awready, 1'b1);
        @(negedge ap_clk);
        s_axi_awvalid = 1'b0;
    endtask

    task automatic ar_send(input logic [AW-1:0] a, input logic [7:0] l);
        int t = 0;
        s_axi_araddr = a; s_axi_arlen = l; s_axi_arvalid = 1'b1;
        while (!s_axi_arready && t < LIM) begin @(negedge ap_clk); t++; end
        chk("ar_handshake", s_axi_arready, 1'b1);
        @(negedge ap_clk);
        s_axi_arvalid = 1'b0;
    endtask

    task automatic w_send(input logic [DW-1:0] d, input logic [SW-1:0] s, input logic last);
        int t = 0;
        s_axi_wdata = d; s_axi_wstrb = s; s_axi_wlast = last; s_axi_wvalid = 1'b1;
        while (!s_axi_wready && t < LIM) begin @(negedge ap_clk); t++; end
        chk("w_handshake", s_axi_wready, 1'b1);
        @(negedge ap_clk);
        s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
    endtask

    task automatic b_wait();
        int t = 0;
        s_axi_bready = 1'b1;
        while (!s_axi_bvalid && t < LIM) begin @(negedge ap_clk); t++; end
        chk("b_valid", s_axi_bvalid, 1'b1);
        chk("aw_quiet_at_b", s_axi_awready, 1'b0);
        @(negedge ap_clk);
        s_axi_bready = 1'b0;
        chk("b_single", s_axi_bvalid, 1'b0);
    endtask

    // wl_beat: index of the beat carrying wlast (len for a well-formed burst)
    task automatic do_write(input logic [AW-1:0] a, input logic [7:0] l,
                            input logic [DW-1:0] d[$], input logic [SW-1:0] s[$], input int wl_beat);
        int idx = widx(a);
        aw_send(a, l);
        for (int i = 0; i <= int'(l); i++) begin
            w_send(d[i], s[i], i == wl_beat);
            for (int b = 0; b < SW; b++)
                if (s[i][b]) mem_m[idx][b*8 +: 8] = d[i][b*8 +: 8];
            idx = (idx + 1) % DEPTH;
        end
        b_wait();
    endtask

    task automatic build_exp(input logic [AW-1:0] a, input logic [7:0] l, output logic [DW-1:0] q[$]);
        q = {};
        for (int i = 0; i <= int'(l); i++) q.push_back(mem_m[(widx(a) + i) % DEPTH]);
    endtask

    // mode 0: rready=1, mode 1: 1,0,0,1 repeating, mode 2: random
    task automatic r_collect(input string tag, input logic [DW-1:0] exp[$], input int mode, input bit chk_lat);
        int n = 0, t = 0, first = -1, last = -1;
        bit stalled = 0;
        logic [DW-1:0] pd = '0;
        logic pl = 1'b0;
        while (n < exp.size() && t < LIM) begin
            case (mode)
                0: s_axi_rready = 1'b1;
                1: s_axi_rready = (t % 4 == 0) || (t % 4 == 3);
                default: s_axi_rready = 1'($urandom_range(0, 1));
            endcase
            if (stalled) begin
                chk({tag, "_hold_valid"}, s_axi_rvalid, 1'b1);
                chk({tag, "_hold_data"}, s_axi_rdata, pd);
                chk({tag, "_hold_last"}, s_axi_rlast, pl);
            end
            if (s_axi_rvalid && s_axi_rready) begin
                chk({tag, "_data"}, s_axi_rdata, exp[n]);
                chk({tag, "_rlast"}, s_axi_rlast, n == exp.size() - 1);
                if (first < 0) first = t;
                last = t;
                n++;
                stalled = 0;
            end else if (s_axi_rvalid) begin
                stalled = 1; pd = s_axi_rdata; pl = s_axi_rlast;
            end else begin
                stalled = 0;
            end
            @(negedge ap_clk);
            t++;
        end
        s_axi_rready = 1'b0;
        chk({tag, "_beats"}, n, exp.size());
        chk({tag, "_no_extra"}, s_axi_rvalid, 1'b0);
        if (chk_lat) begin
            chk({tag, "_first_latency"}, first, 2);
            chk({tag, "_back_to_back"}, last - first, exp.size() - 1);
        end
    endtask

    task automatic do_read(input string tag, input logic [AW-1:0] a, input logic [7:0] l,
                           input int mode, input bit chk_lat);
        logic [DW-1:0] q[$];
        build_exp(a, l, q);
        ar_send(a, l);
        r_collect(tag, q, mode, chk_lat);
    endtask

    initial begin
        logic [DW-1:0] dq[$];
        logic [SW-1:0] sq[$];
        logic [DW-1:0] eq[$];
        logic [DW-1:0] old_v, new_v;
        logic [SW-1:0] ones = '1;

        repeat (3) @(negedge ap_clk);
        chk("rst_awready", s_axi_awready, 1'b0);
        chk("rst_wready", s_axi_wready, 1'b0);
        chk("rst_bvalid", s_axi_bvalid, 1'b0);
        chk("rst_arready", s_axi_arready, 1'b0);
        chk("rst_rvalid", s_axi_rvalid, 1'b0);
        chk("rst_rlast", s_axi_rlast, 1'b0);
        chk("rst_rdata", s_axi_rdata, '0);
        chk("rst_wlast_err", o_wlast_err, 1'b0);
        areset = 1'b0;
        @(negedge ap_clk);

        // preload the whole image with 256-beat bursts, read one burst back
        for (int k = 0; k < 4; k++) begin
            dq = {}; sq = {};
            for (int i = 0; i < 256; i++) begin dq.push_back(rnd512()); sq.push_back(ones); end
            do_write(AW'(k * 256 * SW), 8'd255, dq, sq, 255);
        end
        do_read("rd256", AW'(0), 8'd255, 0, 1'b1);

        // 4-beat write then read: data 1..4, rlast on beat 4, back-to-back beats
        dq = {}; sq = {};
        for (int i = 0; i < 4; i++) begin dq.push_back(DW'(i + 1)); sq.push_back(ones); end
        do_write(AW'(0), 8'd3, dq, sq, 3);
        do_read("t1", AW'(0), 8'd3, 0, 1'b1);

        // byte-enable merge on word 5
        dq = {'1}; sq = {ones};
        do_write(AW'(5 * SW), 8'd0, dq, sq, 0);
        dq = {'0}; sq = {SW'(64'hF)};
        do_write(AW'(64'h140), 8'd0, dq, sq, 0);
        build_exp(AW'(64'h140), 8'd0, eq);
        ar_send(AW'(64'h140), 8'd0);
        r_collect("t2_strb", eq, 0, 1'b1);

        // index wrap at the top of memory
        do_read("t3_wrap", AW'((DEPTH - 1) * SW), 8'd1, 0, 1'b0);

        // rready 1,0,0,1 during an 8-beat read
        do_read("t4_stall", AW'(100 * SW), 8'd7, 1, 1'b0);

        // concurrent 16-beat write and read on disjoint regions
        dq = {}; sq = {};
        for (int i = 0; i < 16; i++) begin dq.push_back(rnd512()); sq.push_back(SW'({$urandom, $urandom})); end
        fork
            do_write(AW'(200 * SW), 8'd15, dq, sq, 15);
            do_read("t5_conc_rd", AW'(600 * SW), 8'd15, 0, 1'b0);
        join
        do_read("t5_conc_wr", AW'(200 * SW), 8'd15, 2, 1'b0);

        // same-word collision: RAM read and write land on the same edge
        old_v = mem_m[700];
        new_v = rnd512();
        aw_send(AW'(700 * SW), 8'd0);
        ar_send(AW'(700 * SW), 8'd0);
        w_send(new_v, ones, 1'b1);
        mem_m[700] = new_v;
        b_wait();
        eq = {old_v};
        r_collect("t5_collide_old", eq, 0, 1'b0);
        do_read("t5_collide_new", AW'(700 * SW), 8'd0, 0, 1'b0);

        // wlast on the first beat of a 2-beat burst
        chk("t6_err_before", o_wlast_err, 1'b0);
        dq = {rnd512(), rnd512()}; sq = {ones, ones};
        do_write(AW'(300 * SW), 8'd1, dq, sq, 0);
        chk("t6_err_set", o_wlast_err, 1'b1);
        do_read("t6_both_beats", AW'(300 * SW), 8'd1, 0, 1'b0);

        // reset in the middle of a read burst
        ar_send(AW'(400 * SW), 8'd7);
        s_axi_rready = 1'b1;
        repeat (4) @(negedge ap_clk);
        areset = 1'b1;
        @(negedge ap_clk);
        chk("t6_rst_rvalid", s_axi_rvalid, 1'b0);
        chk("t6_rst_rlast", s_axi_rlast, 1'b0);
        chk("t6_rst_arready", s_axi_arready, 1'b0);
        chk("t6_rst_err_clr", o_wlast_err, 1'b0);
        s_axi_rready = 1'b0;
        areset = 1'b0;
        @(negedge ap_clk);
        do_read("t6_after_rst", AW'(400 * SW), 8'd7, 0, 1'b1);

        // randomized write/read pairs with unaligned addresses and sparse strobes
        for (int k = 0; k < 8; k++) begin
            int w = $urandom_range(0, DEPTH - 1);
            int l = $urandom_range(0, 7);
            logic [AW-1:0] a = AW'(w * SW + $urandom_range(0, SW - 1));
            dq = {}; sq = {};
            for (int i = 0; i <= l; i++) begin dq.push_back(rnd512()); sq.push_back(SW'({$urandom, $urandom})); end
            do_write(a, 8'(l), dq, sq, l);
            do_read("rand_rd", a, 8'(l), 2, 1'b0);
        end
        chk("final_err_clear", o_wlast_err, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
